fifo_writer_helper: RTL

FIFO_WRITER_HELPER -- requirements
Module: fifo_writer_helper

---
 rtl/ahb3lite_pkg.sv | 20 ++
 rtl/fifo_writer_helper.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg
//   Shared types for the AHB3-Lite support blocks.
//   FIFO_Writer_Help_state : state encoding of fifo_writer_helper
//   FWH_LANES              : byte lanes in one packed FIFO word
//   fwh_fill_word()        : a word with every lane set to the fill byte
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    Writer_IDLE  = 2'd0,
    Writer_PACK  = 2'd1,
    Writer_WRITE = 2'd2
  } FIFO_Writer_Help_state;

  localparam int unsigned FWH_LANES = 4;

  function automatic logic [31:0] fwh_fill_word(input logic [7:0] fill);
    return {FWH_LANES{fill}};
  endfunction

endpackage

// File: rtl/fifo_writer_helper.sv
// fifo_writer_helper
//   Packs a serial byte stream of L bytes (0..63) into little-endian 32-bit
//   words and pushes them into a FIFO. A partial final word has its unused
//   lanes filled with FILL_BYTE.
//
// Parameters
//   FILL_BYTE        : byte value for unused lanes of a partial final word
// Ports
//   CLK              : clock, rising edge
//   RESETn           : synchronous active-low reset
//   Write_Request    : start of transfer, sampled only in IDLE
//   i_BUFFER_LENGTH  : transfer length in bytes, latched at start
//   i_byte           : serial input byte
//   i_byte_valid     : i_byte valid
//   o_byte_ready     : byte accepted this cycle when i_byte_valid is high
//   i_FIFO_full      : FIFO full flag
//   o_FIFO_din       : packed word to FIFO
//   o_FIFO_wr_en     : FIFO write strobe
//   o_busy           : high outside IDLE
//   o_done           : one-cycle pulse at end of transfer
//   o_overflow       : (only with FIFO_WRITER_OVERFLOW_EN) sticky flag, a
//                      byte was offered while IDLE; cleared by a request
//   Pack_Counter     : current byte lane (0..3)
//
// Build option: define FIFO_WRITER_OVERFLOW_EN to add o_overflow.
module fifo_writer_helper
  import ahb3lite_pkg::*;
#(
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        Write_Request,
  input  logic [5:0]  i_BUFFER_LENGTH,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  input  logic        i_FIFO_full,
  output logic [31:0] o_FIFO_din,
  output logic        o_FIFO_wr_en,
  output logic        o_busy,
  output logic        o_done,
`ifdef FIFO_WRITER_OVERFLOW_EN
  output logic        o_overflow,
`endif
  output logic [1:0]  Pack_Counter
);

  FIFO_Writer_Help_state state_q;
  logic [5:0]  len_q;
  logic [6:0]  byte_cnt_q;
  logic [6:0]  byte_cnt_d;
  logic [1:0]  pack_cnt_q;
  logic [31:0] word_q;
  logic        done_q;
  logic        byte_accept;
  logic        last_byte;

  assign byte_accept = (state_q == Writer_PACK) && i_byte_valid;
  assign byte_cnt_d  = byte_cnt_q + 7'd1;
  // Word closes on lane 3 or on the final byte of the transfer.
  assign last_byte   = (pack_cnt_q == 2'd3) || (byte_cnt_d == {1'b0, len_q});

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q    <= Writer_IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      pack_cnt_q <= '0;
      word_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        Writer_IDLE: begin
          if (Write_Request) begin
            if (i_BUFFER_LENGTH != 6'd0) begin
              len_q      <= i_BUFFER_LENGTH;
              byte_cnt_q <= '0;
              pack_cnt_q <= '0;
              word_q     <= fwh_fill_word(FILL_BYTE);
              state_q    <= Writer_PACK;
            end else begin
              // Empty transfer: nothing to write, just report completion.
              done_q <= 1'b1;
            end
          end
        end
        Writer_PACK: begin
          if (byte_accept) begin
            word_q[{pack_cnt_q, 3'b000} +: 8] <= i_byte;
            pack_cnt_q <= pack_cnt_q + 2'd1;
            byte_cnt_q <= byte_cnt_d;
            if (last_byte) state_q <= Writer_WRITE;
          end
        end
        Writer_WRITE: begin
          // The word stays put until the FIFO can take it.
          if (!i_FIFO_full) begin
            if (byte_cnt_q == {1'b0, len_q}) begin
              state_q <= Writer_IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= Writer_PACK;
              pack_cnt_q <= '0;
              word_q     <= fwh_fill_word(FILL_BYTE);
            end
          end
        end
        default: state_q <= Writer_IDLE;
      endcase
    end
  end

`ifdef FIFO_WRITER_OVERFLOW_EN
  logic overflow_q;

  // A byte offered in IDLE is dropped; remember it until the next request.
  // A byte dropped in the same cycle as the request still counts.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      overflow_q <= 1'b0;
    end else if (state_q == Writer_IDLE && i_byte_valid) begin
      overflow_q <= 1'b1;
    end else if (state_q == Writer_IDLE && Write_Request) begin
      overflow_q <= 1'b0;
    end
  end

  assign o_overflow = overflow_q;
`endif

  assign o_byte_ready = (state_q == Writer_PACK);
  assign o_FIFO_wr_en = (state_q == Writer_WRITE) && !i_FIFO_full;
  assign o_FIFO_din   = word_q;
  assign o_busy       = (state_q != Writer_IDLE);
  assign o_done       = done_q;
  assign Pack_Counter = pack_cnt_q;

endmodule
